// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_tx_pkg;

  // Payload bits per frame unless the instantiating code overrides it.
  localparam int DATA_WIDTH_DEF = 8;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Line select encodings driven towards the output mux.
  localparam logic [1:0] MUX_START  = 2'b00;  // line = 0
  localparam logic [1:0] MUX_DATA   = 2'b01;  // line = ser_data
  localparam logic [1:0] MUX_PARITY = 2'b10;  // line = par_bit
  localparam logic [1:0] MUX_IDLE   = 2'b11;  // line = 1 (idle and stop)

endpackage

// File: rtl/uart_tx_ctrl_serializer.sv
// Shift register and bit counter for the data phase of a frame.
// ser_data is the low bit of the shift register, so it is a flop output.
module serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  output logic                  ser_data,
  output logic                  last_bit
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;

  // Load a new payload, or shift right one bit per data cycle (LSB first).
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
  end

  // Count data cycles 0..DATA_WIDTH-1; wrap to zero as the data phase ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  assign ser_data = shreg[0];
  assign last_bit = (bit_cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame sequencer, one-entry holding buffer and
// parity generation. One clk period is one bit time on the line.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  ready,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic [1:0]            mux_sel,
  output logic                  busy
);

  tx_state_e             state;
  logic                  par_en_q;

  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_par_en;
  logic                  buf_par_typ;

  logic                  accept;
  logic                  from_buf;
  logic                  load;
  logic                  buf_wr;
  logic                  shift_en;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_par_en;
  logic                  load_par_typ;

  // Even parity is the XOR of the payload; odd parity is its complement.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic                  odd);
    return (^d) ^ odd;
  endfunction

  assign ready  = buf_empty;
  assign accept = data_valid & buf_empty;

  // A full buffer is drained in STOP; an offer while idle, or while in STOP
  // with nothing buffered, goes straight to the shift register so a buffer
  // write and read never share an edge.
  assign from_buf = (state == STOP) & ~buf_empty;
  assign load     = from_buf | (accept & ((state == IDLE) | (state == STOP)));
  assign buf_wr   = accept & ((state == START) | (state == DATA) | (state == PARITY));

  assign load_data    = from_buf ? buf_data    : P_DATA;
  assign load_par_en  = from_buf ? buf_par_en  : par_en;
  assign load_par_typ = from_buf ? buf_par_typ : par_typ;

  assign shift_en = (state == DATA);

  serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .shift_en  (shift_en),
    .ser_data  (ser_data),
    .last_bit  (last_bit)
  );

  // Holding buffer payload; validity is tracked by buf_empty alone.
  // NOTE: the payload register carries no reset because nothing reads it
  // while buf_empty is set, which reset does force.
  always_ff @(posedge clk) begin
    if (rst && buf_wr) begin
      buf_data <= P_DATA;
    end
  end

  // Frame sequencer with registered line select, busy and parity bit, plus
  // the holding buffer control flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      mux_sel     <= MUX_IDLE;
      busy        <= 1'b0;
      par_bit     <= 1'b0;
      par_en_q    <= 1'b0;
      buf_empty   <= 1'b1;
      buf_par_en  <= 1'b0;
      buf_par_typ <= 1'b0;
    end else begin
      if (buf_wr) begin
        buf_empty   <= 1'b0;
        buf_par_en  <= par_en;
        buf_par_typ <= par_typ;
      end else if (from_buf) begin
        buf_empty <= 1'b1;
      end

      if (load) begin
        // Frame settings are latched here and held until the next load.
        state    <= START;
        mux_sel  <= MUX_START;
        busy     <= 1'b1;
        par_en_q <= load_par_en;
        par_bit  <= calc_parity(load_data, load_par_typ);
      end else begin
        case (state)
          IDLE: begin
            mux_sel <= MUX_IDLE;
            busy    <= 1'b0;
          end
          START: begin
            state   <= DATA;
            mux_sel <= MUX_DATA;
          end
          DATA: begin
            if (last_bit) begin
              if (par_en_q) begin
                state   <= PARITY;
                mux_sel <= MUX_PARITY;
              end else begin
                state   <= STOP;
                mux_sel <= MUX_IDLE;
              end
            end
          end
          PARITY: begin
            state   <= STOP;
            mux_sel <= MUX_IDLE;
          end
          STOP: begin
            state   <= IDLE;
            mux_sel <= MUX_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            mux_sel <= MUX_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected frames, a
// monitor rebuilds each frame from the line controls and compares.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          ready;
  logic          ser_data;
  logic          par_bit;
  logic [1:0]    mux_sel;
  logic          busy;

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          par;
  } frame_t;

  frame_t exp_q[$];
  int     total = 0;
  int     bad   = 0;
  bit     mon_flush = 1'b0;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .ready      (ready),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .mux_sel    (mux_sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a byte for exactly one edge, starting at the current cycle.
  task automatic offer(input logic [DW-1:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [DW-1:0] d, input logic pe, input logic par);
    frame_t f;
    f.data = d;
    f.pe   = pe;
    f.par  = par;
    exp_q.push_back(f);
  endtask

  // Count busy cycles starting from the current (START) cycle.
  task automatic frame_len(output int len);
    len = 0;
    while (busy === 1'b1 && len < 100) begin
      len++;
      tick(1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      n++;
      tick(1);
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    tick(2);
  endtask

  // Monitor: rebuild frames from mux_sel/ser_data/par_bit at negedge.
  initial begin : monitor
    int            pos;
    logic [DW-1:0] rx;
    bit            got_par;
    logic          par_val;
    bit            sel_ok;
    frame_t        e;
    pos = -1;
    rx = '0;
    got_par = 1'b0;
    par_val = 1'b0;
    sel_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_flush) begin
        pos = -1;
        mon_flush = 1'b0;
      end else if (pos < 0) begin
        if (mux_sel == 2'b00) begin
          pos = 0;
          rx = '0;
          got_par = 1'b0;
          par_val = 1'b0;
          sel_ok = (busy === 1'b1);
        end
      end else begin
        pos++;
        if (busy !== 1'b1) sel_ok = 1'b0;
        if (pos <= DW) begin
          if (mux_sel !== 2'b01) sel_ok = 1'b0;
          rx[3'(pos - 1)] = ser_data;
        end else if (pos == DW + 1 && mux_sel == 2'b10) begin
          got_par = 1'b1;
          par_val = par_bit;
        end else begin
          if (mux_sel !== 2'b11) sel_ok = 1'b0;
          if (exp_q.size() == 0) begin
            check("frame_expected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", {24'd0, rx}, {24'd0, e.data});
            check("frame_has_parity", {31'd0, got_par}, {31'd0, e.pe});
            if (e.pe) check("frame_parity", {31'd0, par_val}, {31'd0, e.par});
            check("frame_line_sequence", {31'd0, sel_ok}, 32'd1);
          end
          pos = -1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int len;
    bit activity;
    rst        = 1'b0;
    data_valid = 1'b0;
    P_DATA     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    tick(3);

    // Reset state.
    check("rst_mux_sel",  {30'd0, mux_sel}, 32'd3);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_ready",    {31'd0, ready},    32'd1);
    check("rst_ser_data", {31'd0, ser_data}, 32'd0);
    check("rst_par_bit",  {31'd0, par_bit},  32'd0);
    rst = 1'b1;
    tick(2);

    // 8N1, 0xA5: line bits 1,0,1,0,0,1,0,1, ten busy cycles.
    expect_frame(8'hA5, 1'b0, 1'b0);
    offer(8'hA5, 1'b0, 1'b0);
    check("8n1_start_sel",   {30'd0, mux_sel}, 32'd0);
    check("8n1_start_busy",  {31'd0, busy},    32'd1);
    check("8n1_bypass_ready", {31'd0, ready},  32'd1);
    frame_len(len);
    check("8n1_len", len, 10);
    check("8n1_idle_sel", {30'd0, mux_sel}, 32'd3);
    tick(2);

    // 8E1, 0xB3 (five ones -> even parity bit 1); settings changed mid-frame.
    expect_frame(8'hB3, 1'b1, 1'b1);
    offer(8'hB3, 1'b1, 1'b0);
    par_en  = 1'b0;
    par_typ = 1'b1;
    frame_len(len);
    check("8e1_len", len, 11);
    tick(2);

    // 8O1, 0xB3 -> odd parity bit 0.
    expect_frame(8'hB3, 1'b1, 1'b0);
    offer(8'hB3, 1'b1, 1'b1);
    frame_len(len);
    check("8o1_len", len, 11);
    tick(2);

    // Back-to-back: 0x55, then 0x0F offered in DATA cycle 3.
    expect_frame(8'h55, 1'b0, 1'b0);
    expect_frame(8'h0F, 1'b0, 1'b0);
    offer(8'h55, 1'b0, 1'b0);
    tick(4);
    offer(8'h0F, 1'b0, 1'b0);
    check("b2b_ready_low", {31'd0, ready}, 32'd0);
    tick(4);
    check("b2b_stop_sel",   {30'd0, mux_sel}, 32'd3);
    check("b2b_stop_ready", {31'd0, ready},   32'd0);
    tick(1);
    check("b2b_second_start", {30'd0, mux_sel}, 32'd0);
    check("b2b_ready_back",   {31'd0, ready},   32'd1);
    check("b2b_busy_held",    {31'd0, busy},    32'd1);
    wait_idle("b2b");

    // Overflow: 0xC3 sent, 0x97 (8E1, five ones -> 1) buffered, 0x7E ignored.
    expect_frame(8'hC3, 1'b0, 1'b0);
    expect_frame(8'h97, 1'b1, 1'b1);
    offer(8'hC3, 1'b0, 1'b0);
    tick(2);
    offer(8'h97, 1'b1, 1'b0);
    check("ovf_ready_low", {31'd0, ready}, 32'd0);
    offer(8'h7E, 1'b0, 1'b0);
    check("ovf_still_full", {31'd0, ready}, 32'd0);
    wait_idle("ovf");

    // Mid-frame reset in DATA cycle 4 with the buffer full.
    offer(8'hE1, 1'b0, 1'b0);
    tick(1);
    offer(8'h12, 1'b0, 1'b0);
    tick(3);
    rst        = 1'b0;
    P_DATA     = 8'h44;
    data_valid = 1'b1;
    mon_flush  = 1'b1;
    exp_q.delete();
    tick(1);
    data_valid = 1'b0;
    rst        = 1'b1;
    check("mrst_sel",   {30'd0, mux_sel}, 32'd3);
    check("mrst_busy",  {31'd0, busy},    32'd0);
    check("mrst_ready", {31'd0, ready},   32'd1);
    activity = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (busy !== 1'b0 || mux_sel !== 2'b11) activity = 1'b1;
    end
    check("mrst_no_resume", {31'd0, activity}, 32'd0);

    // Write during STOP with the buffer empty: START directly, no IDLE cycle.
    // 0x81 has two ones -> odd parity bit 1.
    expect_frame(8'h3C, 1'b0, 1'b0);
    expect_frame(8'h81, 1'b1, 1'b1);
    offer(8'h3C, 1'b0, 1'b0);
    tick(9);
    check("stopwr_in_stop", {30'd0, mux_sel}, 32'd3);
    check("stopwr_busy",    {31'd0, busy},    32'd1);
    offer(8'h81, 1'b1, 1'b1);
    check("stopwr_start", {30'd0, mux_sel}, 32'd0);
    check("stopwr_ready", {31'd0, ready},   32'd1);
    wait_idle("stopwr");

    tick(3);
    check("frames_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 SHALL have port clk  input  1  bit clock; one clk period equals one bit time on the line.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 SHALL have port data_valid  input  1  P_DATA valid; accepted on a clk edge where ready=1.
REQ-006 SHALL have port par_en  input  1  parity bit enable; sampled with the accepted byte.
REQ-007 SHALL have port par_typ  input  1  parity type, 0=even, 1=odd; sampled with the accepted byte.
REQ-008 SHALL have port ready  output  1  high when the one-entry holding buffer is empty.
REQ-009 SHALL have port ser_data  output  1  current data bit, LSB first, to the output mux.
REQ-010 SHALL have port par_bit  output  1  parity bit of the frame in flight, to the output mux.
REQ-011 SHALL have port mux_sel  output  2  line select: 00 start(0), 01 ser_data, 10 par_bit, 11 idle/stop(1).
REQ-012 SHALL have port busy  output  1  high while a frame is on the line (START through STOP).

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; each state drives mux_sel 11, 00, 01, 10, 11 respectively.
REQ-014 All outputs SHALL be registered; mux_sel, ser_data, par_bit and busy change only on the clk edge.
REQ-015 IDLE with data_valid=1 at edge N SHALL load the byte into the shift register; START is active after edge N, with busy=1 and mux_sel=00.
REQ-016 START SHALL last 1 cycle and then go to DATA.
REQ-017 DATA SHALL last exactly DATA_WIDTH cycles; ser_data = P_DATA[i] in DATA cycle i, i=0..DATA_WIDTH-1.
REQ-018 Bit counter SHALL be clog2(DATA_WIDTH) bits wide, count 0..DATA_WIDTH-1, and clear on leaving DATA.
REQ-019 After DATA the FSM SHALL go to PARITY when the latched par_en=1, otherwise to STOP.
REQ-020 PARITY SHALL last 1 cycle; par_bit = XOR of the byte for even parity and its complement for odd parity.
REQ-021 par_bit SHALL be computed once at byte load and held stable for the whole frame.
REQ-022 STOP SHALL last 1 cycle; next state is START when the holding buffer is full, otherwise IDLE.
REQ-023 STOP-to-START SHALL move the buffered byte and its par_en/par_typ into the shift register, giving back-to-back frames with no idle cycle.
REQ-024 While busy=1, data_valid with ready=1 SHALL capture P_DATA/par_en/par_typ into the holding buffer; ready goes low on the next cycle.
REQ-025 data_valid while ready=0 SHALL be ignored; no state, buffer or output change.
REQ-026 Buffer write in STOP and buffer read in the same edge SHALL NOT occur; in STOP with the buffer empty, a write fills it and the FSM takes START directly.
REQ-027 In IDLE, an accepted byte SHALL bypass the buffer; ready stays 1.
REQ-028 Frame length SHALL be 2+DATA_WIDTH+par_en cycles: 10 for 8N1, 11 for 8E1.
REQ-029 par_en/par_typ changes mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-030 With rst=0 at a clk edge: state IDLE, mux_sel=11, busy=0, ready=1, ser_data=0, par_bit=0, bit counter 0, buffer empty.
REQ-031 Reset asserted mid-frame SHALL abort the frame and discard the buffered byte; the line returns to idle-high the next cycle.
REQ-032 data_valid SHALL be ignored on any edge where rst=0.

Structure
REQ-033 Package uart_tx_pkg SHALL hold the FSM state enum, the four mux_sel encodings and the DATA_WIDTH default.
REQ-034 Sub-module serializer SHALL hold the shift register, load strobe, shift enable and bit counter, and SHALL flag the last data bit to the FSM.
REQ-035 The FSM, holding buffer and parity logic SHALL reside in uart_tx_ctrl.

Verification
REQ-036 8N1: P_DATA=0xA5, par_en=0 in IDLE -> mux_sel 00, 01x8, 11; ser_data 1,0,1,0,0,1,0,1; busy high for 10 cycles.
REQ-037 8E1/8O1: P_DATA=0xB3, par_en=1 -> PARITY cycle with par_bit=1 for even, 0 for odd; frame 11 cycles.
REQ-038 Back-to-back: 0x55 accepted, then 0x0F at DATA cycle 3 -> ready=0 until STOP; second START immediately after first STOP.
REQ-039 Overflow: three bytes offered during one frame -> only the first two are transmitted; the third is ignored while ready=0.
REQ-040 Mid-frame reset: rst=0 in DATA cycle 4 with buffer full -> next cycle mux_sel=11, busy=0, ready=1; nothing resumes after release.
REQ-041 STOP-cycle write: data_valid=1 in STOP with buffer empty -> START on the next cycle, no IDLE cycle.
